fetch_sequencer: RTL and testbench

- Moore FSM that runs the instruction-fetch micro-sequence (T0–T2) over the shared 32-bit CPU bus.
- Drives the bus-source selects PCout, Zlowout and MDRout, plus the matching register-load, ALU and memory strobes.
- Waits on a memory-ready handshake, with a bounded timeout.
- Hands off to the execute control logic via a start/done handshake.

---
 rtl/fetch_sequencer_pkg.sv | 31 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU control package: fetch-sequencer state encoding, default memory
// wait bound, and the one-hot bus-source select positions that every control
// sequencer driving the shared 32-bit CPU bus agrees on.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T1W  = 3'd3,
        ST_T2   = 3'd4,
        ST_ERR  = 3'd5
    } fetch_state_t;

    localparam int unsigned MAX_WAIT_DEFAULT = 8;
    localparam int unsigned WAIT_CNT_W       = 8;

    // One-hot bus source select, one bit per bus driver.
    localparam int BUS_SEL_W = 3;
    localparam int BUS_PC    = 0;
    localparam int BUS_ZLOW  = 1;
    localparam int BUS_MDR   = 2;

    typedef logic [BUS_SEL_W-1:0] bus_sel_t;

    localparam bus_sel_t BUS_SEL_NONE = '0;
    localparam bus_sel_t BUS_SEL_PC   = bus_sel_t'(1 << BUS_PC);
    localparam bus_sel_t BUS_SEL_ZLOW = bus_sel_t'(1 << BUS_ZLOW);
    localparam bus_sel_t BUS_SEL_MDR  = bus_sel_t'(1 << BUS_MDR);

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch micro-sequencer (T0..T2) for the shared CPU bus.
// Moore FSM: every strobe is decoded from the current state only.
//
// Ports:
//   clock, clear       rising-edge clock, synchronous active-high reset
//   start              request a fetch (sampled in IDLE and T2)
//   abort              cancel the fetch in progress (T0/T1/T1W/T2)
//   mem_ready          memory read data valid this cycle
//   PCout/Zlowout/MDRout  bus source selects (at most one high)
//   MARin/IncPC/Zin/PCin/Read/MDRin/IRin  register-load, ALU and memory strobes
//   fetch_busy         high whenever not IDLE
//   fetch_done         one-cycle pulse, IR loaded
//   fetch_err          one-cycle pulse, memory timeout
//   fetch_count        completed fetches, wraps modulo 2^CNT_W
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no strobes, waiting for start
// T0    | PC -> bus -> MAR, ALU computes PC+1 into Z
// T1    | Zlow -> bus -> PC, issue memory read, clear wait counter
// T1W   | memory wait state, read held, bounded by MAX_WAIT cycles
// T2    | MDR -> bus -> IR, fetch done
// ERR   | memory timeout pulse, back to IDLE
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             IRin,
    output logic             fetch_busy,
    output logic             fetch_done,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    bus_sel_t              bus_sel;

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_T1) begin
                wait_cnt <= '0;
            end else if (state == ST_T1W) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // T2 always lasts one cycle and IRin fires there even when
            // aborted, so every T2 cycle is a completed fetch.
            if (state == ST_T2) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        bus_sel    = BUS_SEL_NONE;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        fetch_done = 1'b0;
        fetch_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_T0;
            end
            ST_T0: begin
                bus_sel   = BUS_SEL_PC;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                state_nxt = abort ? ST_IDLE : ST_T1;
            end
            ST_T1: begin
                bus_sel = BUS_SEL_ZLOW;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (abort)          state_nxt = ST_IDLE;
                else if (mem_ready) state_nxt = ST_T2;
                else                state_nxt = ST_T1W;
            end
            ST_T1W: begin
                // PCin stays low here: the PC must advance once per fetch.
                Read  = 1'b1;
                MDRin = 1'b1;
                if (abort)                      state_nxt = ST_IDLE;
                else if (mem_ready)             state_nxt = ST_T2;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_ERR;
            end
            ST_T2: begin
                bus_sel    = BUS_SEL_MDR;
                IRin       = 1'b1;
                fetch_done = 1'b1;
                if (abort)      state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_T0;
                else            state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                fetch_err = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign PCout      = bus_sel[BUS_PC];
    assign Zlowout    = bus_sel[BUS_ZLOW];
    assign MDRout     = bus_sel[BUS_MDR];
    assign fetch_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Expected strobe traces are built
// per fetch from the micro-sequence rules (T0, T1, wait cycles, T2 or ERR).
module tb_fetch_sequencer;

    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 16;

    // {PCout,Zlowout,MDRout,MARin,IncPC,Zin,PCin,Read,MDRin,IRin,busy,done,err}
    localparam logic [12:0] V_IDLE = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] V_T0   = 13'b1_0_0_1_1_1_0_0_0_0_1_0_0;
    localparam logic [12:0] V_T1   = 13'b0_1_0_0_0_0_1_1_1_0_1_0_0;
    localparam logic [12:0] V_T1W  = 13'b0_0_0_0_0_0_0_1_1_0_1_0_0;
    localparam logic [12:0] V_T2   = 13'b0_0_1_0_0_0_0_0_0_1_1_1_0;
    localparam logic [12:0] V_ERR  = 13'b0_0_0_0_0_0_0_0_0_0_1_0_1;

    logic clock = 1'b0;
    logic clear, start, abort, mem_ready;
    logic PCout, Zlowout, MDRout, MARin, IncPC, Zin, PCin, Read, MDRin, IRin;
    logic fetch_busy, fetch_done, fetch_err;
    logic [CNT_W-1:0] fetch_count;

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b0;
    logic [CNT_W-1:0] count_model;
    logic [12:0] exp_q[$];

    fetch_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clock(clock), .clear(clear), .start(start), .abort(abort),
        .mem_ready(mem_ready), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .IRin(IRin), .fetch_busy(fetch_busy),
        .fetch_done(fetch_done), .fetch_err(fetch_err), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [12:0] outs();
        return {PCout, Zlowout, MDRout, MARin, IncPC, Zin, PCin, Read, MDRin,
                IRin, fetch_busy, fetch_done, fetch_err};
    endfunction

    // Expected trace of one fetch whose memory answers w cycles after T1
    // (w=0: zero-wait). Beyond MAX_WAIT wait cycles the fetch times out.
    function automatic void expect_fetch(input int w);
        int nw;
        exp_q.delete();
        exp_q.push_back(V_T0);
        exp_q.push_back(V_T1);
        nw = (w > MAX_WAIT) ? MAX_WAIT : w;
        for (int k = 0; k < nw; k++) exp_q.push_back(V_T1W);
        exp_q.push_back((w <= MAX_WAIT) ? V_T2 : V_ERR);
    endfunction

    always @(negedge clock) begin
        if (running) begin
            checks++;
            if (int'(PCout) + int'(Zlowout) + int'(MDRout) > 1) begin
                $display("FAIL bus_invariant t=%0t: PCout=%b Zlowout=%b MDRout=%b, need at most one high",
                         $time, PCout, Zlowout, MDRout);
                failures++;
            end
        end
    end

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        running = 1'b1;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== '0) begin
            $display("FAIL reset_init: outs=%b cnt=%0d, need %b cnt=0", outs(), fetch_count, V_IDLE);
            failures++;
        end
        clear = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (outs() !== V_T1W) begin
            $display("FAIL reset_reach_t1w: outs=%b, need %b", outs(), V_T1W);
            failures++;
        end
        clear = 1'b1; start = 1'b1; abort = 1'b1; mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (outs() !== V_IDLE || fetch_count !== '0) begin
                $display("FAIL reset_mid_t1w c%0d: outs=%b cnt=%0d, need %b cnt=0", c, outs(), fetch_count, V_IDLE);
                failures++;
            end
        end
        clear = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (outs() !== V_IDLE || fetch_count !== '0) begin
            $display("FAIL reset_release: outs=%b cnt=%0d, need %b cnt=0", outs(), fetch_count, V_IDLE);
            failures++;
        end
        count_model = '0;
    endtask

    task automatic test_zero_wait();
        int pcin_seen = 0;
        start = 1'b1; mem_ready = 1'($urandom);
        expect_fetch(0);
        foreach (exp_q[i]) begin
            @(negedge clock);
            start = 1'b0;
            mem_ready = (i == 0) ? 1'($urandom) : 1'b1;
            checks++;
            if (outs() !== exp_q[i] || fetch_count !== count_model) begin
                $display("FAIL zero_wait cyc%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                         i + 1, outs(), fetch_count, exp_q[i], count_model);
                failures++;
            end
            if (PCin) pcin_seen++;
            if (exp_q[i] == V_T2) count_model++;
        end
        @(negedge clock);
        mem_ready = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL zero_wait_end: outs=%b cnt=%0d, need %b cnt=%0d", outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
        checks++;
        if (pcin_seen != 1) begin
            $display("FAIL zero_wait_pcin: PCin seen %0d times, need 1", pcin_seen);
            failures++;
        end
    endtask

    task automatic test_wait_states();
        int done_cyc = -1;
        start = 1'b1; mem_ready = 1'b0;
        expect_fetch(3);
        foreach (exp_q[i]) begin
            @(negedge clock);
            start = (exp_q[i] == V_T2) ? 1'b0 : 1'($urandom);
            mem_ready = (i == 0) ? 1'($urandom) : (i >= 4);
            checks++;
            if (outs() !== exp_q[i] || fetch_count !== count_model) begin
                $display("FAIL wait_states cyc%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                         i + 1, outs(), fetch_count, exp_q[i], count_model);
                failures++;
            end
            if (fetch_done) done_cyc = i + 1;
            if (exp_q[i] == V_T2) count_model++;
        end
        @(negedge clock);
        start = 1'b0; mem_ready = 1'b0;
        checks++;
        if (done_cyc != 6 || outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL wait_states_end: done_cyc=%0d outs=%b cnt=%0d, need 6 %b cnt=%0d",
                     done_cyc, outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
    endtask

    task automatic test_timeout();
        int t1w_seen = 0;
        int done_seen = 0;
        start = 1'b1; mem_ready = 1'b0;
        expect_fetch(MAX_WAIT + 1);
        foreach (exp_q[i]) begin
            @(negedge clock);
            start = 1'($urandom);
            mem_ready = (i == 0) ? 1'($urandom) : 1'b0;
            checks++;
            if (outs() !== exp_q[i] || fetch_count !== count_model) begin
                $display("FAIL timeout cyc%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                         i + 1, outs(), fetch_count, exp_q[i], count_model);
                failures++;
            end
            if (outs() == V_T1W) t1w_seen++;
            if (fetch_done) done_seen++;
        end
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (t1w_seen != MAX_WAIT || done_seen != 0 || outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL timeout_end: t1w=%0d done=%0d outs=%b cnt=%0d, need %0d 0 %b cnt=%0d",
                     t1w_seen, done_seen, outs(), fetch_count, MAX_WAIT, V_IDLE, count_model);
            failures++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int w = int'($urandom_range(0, MAX_WAIT + 2));
            abort = 1'b0; start = 1'b1; mem_ready = 1'($urandom);
            expect_fetch(w);
            foreach (exp_q[i]) begin
                @(negedge clock);
                start = (exp_q[i] == V_T2) ? 1'b0 : 1'($urandom);
                mem_ready = (i == 0) ? 1'($urandom) : (i >= 1 + w);
                abort = (exp_q[i] == V_ERR) ? 1'($urandom) : 1'b0;
                checks++;
                if (outs() !== exp_q[i] || fetch_count !== count_model) begin
                    $display("FAIL random f%0d w%0d cyc%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                             n, w, i + 1, outs(), fetch_count, exp_q[i], count_model);
                    failures++;
                end
                if (exp_q[i] == V_T2) count_model++;
            end
            for (int g = 0; g <= int'($urandom_range(0, 2)); g++) begin
                @(negedge clock);
                start = 1'b0; abort = 1'($urandom); mem_ready = 1'($urandom);
                checks++;
                if (outs() !== V_IDLE || fetch_count !== count_model) begin
                    $display("FAIL random_idle f%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                             n, outs(), fetch_count, V_IDLE, count_model);
                    failures++;
                end
            end
        end
        abort = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] seq[3] = '{V_T0, V_T1, V_T2};
        logic [12:0] fifth[4] = '{V_T0, V_T1, V_T1W, V_T1W};
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        count_model = '0;
        start = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checks++;
            if (outs() !== seq[k % 3] || fetch_count !== count_model) begin
                $display("FAIL b2b cyc%0d: outs=%b cnt=%0d, need %b cnt=%0d",
                         k + 1, outs(), fetch_count, seq[k % 3], count_model);
                failures++;
            end
            if (seq[k % 3] == V_T2) count_model++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            mem_ready = 1'b0;
            if (k == 3) begin
                abort = 1'b1; start = 1'b0;
            end
            checks++;
            if (outs() !== fifth[k] || fetch_count !== 16'd4) begin
                $display("FAIL b2b_fifth cyc%0d: outs=%b cnt=%0d, need %b cnt=4",
                         k + 1, outs(), fetch_count, fifth[k]);
                failures++;
            end
        end
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== 16'd4) begin
            $display("FAIL b2b_abort: outs=%b cnt=%0d, need %b cnt=4", outs(), fetch_count, V_IDLE);
            failures++;
        end
    endtask

    task automatic test_abort();
        // abort in T0
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL abort_t0: outs=%b cnt=%0d, need %b cnt=%0d", outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
        // abort in T1 beats mem_ready
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        abort = 1'b1; mem_ready = 1'b1;
        @(negedge clock);
        abort = 1'b0; mem_ready = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL abort_t1: outs=%b cnt=%0d, need %b cnt=%0d", outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
        // abort in T2 beats start, IRin still fires and the fetch counts
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        mem_ready = 1'b1;
        @(negedge clock);
        abort = 1'b1; mem_ready = 1'b0;
        checks++;
        if (outs() !== V_T2) begin
            $display("FAIL abort_t2_outs: outs=%b, need %b", outs(), V_T2);
            failures++;
        end
        count_model++;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL abort_t2: outs=%b cnt=%0d, need %b cnt=%0d", outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (outs() !== V_IDLE || fetch_count !== count_model) begin
            $display("FAIL abort_idle: outs=%b cnt=%0d, need %b cnt=%0d", outs(), fetch_count, V_IDLE, count_model);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_random();
        test_abort();
        test_back_to_back();
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
